// File: rtl/ysyx_23060061_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// MEM_RAND_DELAY_EN (optional) adds LFSR-based random extra latency in the top.
package ysyx_23060061_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting left: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Wide enough for LATENCY-1 (max 14) plus up to 7 random extra cycles.
  localparam int CNT_W = 5;

endpackage

// File: rtl/ysyx_23060061_lfsr8.sv
// 8-bit Fibonacci LFSR, reseeded on reset and advancing every cycle.
// Only instantiated when MEM_RAND_DELAY_EN is defined.
module ysyx_23060061_lfsr8
  import ysyx_23060061_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst) r_lfsr <= LFSR_SEED;
    else      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign out = r_lfsr;

endmodule

// File: rtl/ysyx_23060061_mem_responder.sv
// Word-addressed data-memory responder with valid/ready request and response channels.
// Define MEM_RAND_DELAY_EN to stretch each access by a pseudo-random 0..7 extra cycles.
module ysyx_23060061_mem_responder
  import ysyx_23060061_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  state_e              r_state;
  state_e              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_load;
  logic                r_req_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_accept;
  logic                w_go_resp;

  logic                r_wen;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NB-1:0]       r_wmask;

  logic [DATA_W-1:0]   r_mem [DEPTH];

`ifdef MEM_RAND_DELAY_EN
  logic [7:0] w_lfsr;

  ysyx_23060061_lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (w_lfsr)
  );

  assign w_load = CNT_W'(LATENCY - 1) + CNT_W'(w_lfsr & 8'h07);
`else
  assign w_load = CNT_W'(LATENCY - 1);
`endif

  // With a zero-length wait the access happens on the accept edge, so it must
  // see the live request fields rather than the not-yet-latched copies.
  logic                w_wen;
  logic [31:0]         w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [NB-1:0]       w_wmask;
  logic [32:0]         w_off;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;

  assign w_wen      = (r_state == IDLE) ? req_wen   : r_wen;
  assign w_addr     = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata    = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_wmask    = (r_state == IDLE) ? req_wmask : r_wmask;
  assign w_off      = {1'b0, w_addr} - {1'b0, BASE};
  assign w_in_range = !w_off[32] && ((w_off[31:0] >> 2) < DEPTH);
  assign w_idx      = IDX_W'(w_off[31:0] >> 2);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_go_resp  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req_ready && req_valid) begin
          w_accept = 1'b1;
          if (w_load == '0) begin
            w_next    = RESP;
            w_go_resp = 1'b1;
          end else begin
            w_next     = WAIT;
            w_cnt_next = w_load;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next    = RESP;
          w_go_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rdata     <= '0;
      r_err       <= RESP_OK;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next == IDLE);
      if (w_go_resp) begin
        r_rdata <= (!w_wen && w_in_range) ? r_mem[w_idx] : '0;
        r_err   <= w_in_range ? RESP_OK : RESP_ERR;
      end
    end
  end

  // NOTE: the storage array and request latches carry no reset; their contents
  // are only meaningful after a write or an accept, and a reset would force
  // the array out of RAM into flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= req_wen;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
    if (rst && w_go_resp && w_wen && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060061_mem_responder.sv
// Directed bench for the memory responder; covers handshake timing, masking,
// range errors, back-pressure, mid-operation reset and (optionally) random delay.
module tb_ysyx_23060061_mem_responder;

  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 4096;
`ifdef MEM_RAND_DELAY_EN
  localparam int LAT_MAX = LATENCY + 7;
`else
  localparam int LAT_MAX = LATENCY;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_23060061_mem_responder #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .BASE    (BASE),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Presents a request until accepted, then waits for resp_valid.
  // lat = number of clock edges from accept to resp_valid.
  task automatic issue(input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       output int lat, output logic ok);
    int guard;
    ok    = 1'b1;
    guard = 0;
    lat   = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      ok        = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble the fields: the DUT must use what it sampled at accept.
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_wmask = ~wmask;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) ok = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic ok);
    issue(wen, addr, wdata, wmask, lat, ok);
    rdata = resp_rdata;
    err   = resp_err;
    if (ok) finish_resp();
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got rr=%b rv=%b err=%b rdata=%h exp 0 0 0 00000000",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_rise got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ok);
    n_vec++;
    if (!ok || lat < LATENCY || lat > LAT_MAX || er !== 1'b0 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL write_full got ok=%b lat=%0d err=%b rdata=%h exp lat %0d..%0d err 0 rdata 0",
               ok, lat, er, rd, LATENCY, LAT_MAX);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || lat < LATENCY || lat > LAT_MAX || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_back got ok=%b lat=%0d err=%b rdata=%h exp err 0 rdata deadbeef",
               ok, lat, er, rd);
    end
    // Misaligned address bits are ignored.
    do_req(1'b0, 32'h8000_0013, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_unaligned got ok=%b err=%b rdata=%h exp deadbeef", ok, er, rd);
    end
  endtask

  task automatic test_masked_write();
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    do_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, lat, ok);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'hDE22_BE44) begin
      n_bad++;
      $display("FAIL masked_write got ok=%b err=%b rdata=%h exp de22be44", ok, er, rd);
    end
    do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL zero_mask_ack got ok=%b err=%b rdata=%h exp err 0 rdata 0", ok, er, rd);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || rd !== 32'hDE22_BE44) begin
      n_bad++;
      $display("FAIL zero_mask_unchanged got ok=%b rdata=%h exp de22be44", ok, rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    do_req(1'b1, BASE, 32'hCAFE_F00D, 4'hF, rd, er, lat, ok);
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_below got ok=%b err=%b rdata=%h exp err 1 rdata 0", ok, er, rd);
    end
    do_req(1'b0, 32'h8000_4000, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_above got ok=%b err=%b rdata=%h exp err 1 rdata 0", ok, er, rd);
    end
    // Index 4096 would alias word 0 if the range check were missing.
    do_req(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_write got ok=%b err=%b rdata=%h exp err 1 rdata 0", ok, er, rd);
    end
    do_req(1'b0, BASE, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL oor_no_alias got ok=%b err=%b rdata=%h exp cafef00d", ok, er, rd);
    end
    do_req(1'b1, 32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, rd, er, lat, ok);
    do_req(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL last_word got ok=%b err=%b rdata=%h exp 0badf00d", ok, er, rd);
    end
  endtask

  task automatic test_back_pressure();
    logic ok;
    int   lat;
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, ok);
    n_vec++;
    if (!ok || resp_rdata !== 32'hDE22_BE44 || resp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_first got ok=%b rdata=%h err=%b exp de22be44 0", ok, resp_rdata, resp_err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDE22_BE44 || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got rv=%b rdata=%h err=%b rr=%b exp 1 de22be44 0 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    finish_resp();
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got rr=%b rv=%b exp 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'h8000_0100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'hF, rd, er, lat, ok);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'h8000_0100 + 32'(4 * i), 32'h0, 4'h0, rd, er, lat, ok);
      n_vec++;
      if (!ok || rd !== 32'hA0A0_0000 + 32'(i)) begin
        n_bad++;
        $display("FAIL b2b_read_%0d got ok=%b rdata=%h exp %h", i, ok, rd, 32'hA0A0_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          guard;
    int          lat;
    do_req(1'b1, 32'h8000_0020, 32'h0102_0304, 4'hF, rd, er, lat, ok);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'hAAAA_AAAA;
    req_wmask = 4'hF;
    guard     = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL midop_reset got rr=%b rv=%b err=%b rdata=%h exp 0 0 0 00000000",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b1;
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat, ok);
    n_vec++;
    if (!ok || er !== 1'b0 || rd !== 32'h0102_0304) begin
      n_bad++;
      $display("FAIL midop_no_commit got ok=%b err=%b rdata=%h exp 01020304", ok, er, rd);
    end
  endtask

`ifdef MEM_RAND_DELAY_EN
  task automatic test_rand_delay();
    int          lats [2][64];
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    for (int p = 0; p < 2; p++) begin
      apply_reset();
      for (int i = 0; i < 64; i++) begin
        do_req(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, rd, er, lat, ok);
        lats[p][i] = lat;
        n_vec++;
        if (!ok || lat < LATENCY || lat > LATENCY + 7) begin
          n_bad++;
          $display("FAIL rand_range_%0d_%0d got ok=%b lat=%0d exp %0d..%0d",
                   p, i, ok, lat, LATENCY, LATENCY + 7);
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (lats[1][i] !== lats[0][i]) begin
        n_bad++;
        $display("FAIL rand_repeat_%0d got %0d exp %0d", i, lats[1][i], lats[0][i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_out_of_range();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef MEM_RAND_DELAY_EN
    test_rand_delay();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
